// File: rtl/beam_sum_sequencer_pkg.sv
// beam_sum_sequencer_pkg: shared delay/sum datapath defaults and sequencer FSM encoding
package beam_sum_sequencer_pkg;
  localparam int N_CH_DEF   = 8;
  localparam int N_SAMP_DEF = 768;
  localparam int RD_LAT_DEF = 2;
  localparam int DW_DEF     = 32;
  localparam int SW_DEF     = 40;
  localparam int AW_DEF     = 13;
  localparam int SAW_DEF    = 10;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_e;
endpackage

// File: rtl/beam_sum_sequencer_if.sv
// beam_sum_sequencer_if: start/busy/done control, output-RAM read bus and sum-RAM write bus; master = sequencer, slave = environment
interface beam_sum_sequencer_if
  import beam_sum_sequencer_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int SW  = SW_DEF,
  parameter int AW  = AW_DEF,
  parameter int SAW = SAW_DEF
);
  logic           start;
  logic           busy;
  logic           done;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  rd_data;
  logic           wr_en;
  logic [SAW-1:0] wr_addr;
  logic [SW-1:0]  wr_data;
  modport master (input start, rd_data, output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data);
  modport slave (output start, rd_data, input busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/beam_sum_sequencer_rd_valid_pipe.sv
// rd_valid_pipe: RD_LAT-deep shift of rd_en marking read data returns; ports clk, reset, rd_en in, rd_vld out
module rd_valid_pipe
  import beam_sum_sequencer_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic rd_en,
  output logic rd_vld
);
  logic [RD_LAT-1:0] v_q, v_d;
  always_comb v_d = (v_q << 1) | RD_LAT'(rd_en);
  always_ff @(posedge clk) v_q <= reset ? '0 : v_d;
  assign rd_vld = v_q[RD_LAT-1];
endmodule

// File: rtl/beam_sum_sequencer.sv
// beam_sum_sequencer: per sample t reads N_CH channel words at t+N_SAMP*ch, sums them and writes the sum at t; ports clk, reset, bus (master)
module beam_sum_sequencer
  import beam_sum_sequencer_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int N_SAMP = N_SAMP_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int DW     = DW_DEF,
  parameter int SW     = SW_DEF,
  parameter int AW     = AW_DEF,
  parameter int SAW    = SAW_DEF
) (
  input logic clk,
  input logic reset,
  beam_sum_sequencer_if.master bus
);
  localparam int CW = $clog2(N_CH + 1);
  state_e         state_q, state_d;
  logic [SAW-1:0] t_q, t_d, wr_addr_q, wr_addr_d;
  logic [CW-1:0]  ch_q, ch_d, ret_q, ret_d;
  logic [SW-1:0]  acc_q, acc_d, wr_data_q, wr_data_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d;
  logic           rd_en_q, rd_en_d, wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
  logic [DW-1:0]  rd_word;
  logic           vld;
  assign rd_word = bus.rd_data;
  rd_valid_pipe #(.RD_LAT(RD_LAT)) u_rd_valid_pipe (.clk, .reset, .rd_en(rd_en_q), .rd_vld(vld));
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    ch_d    = ch_q;
    acc_d   = vld ? acc_q + SW'(rd_word) : acc_q;
    ret_d   = vld ? ret_q + 1'b1 : ret_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = ISSUE;
        t_d     = '0;
        ch_d    = '0;
        acc_d   = '0;
        ret_d   = '0;
      end
      ISSUE: if (ch_q == CW'(N_CH - 1)) state_d = WAIT; else ch_d = ch_q + 1'b1;
      WAIT: if (ret_d == CW'(N_CH)) state_d = WRITE;
      WRITE: begin
        acc_d = '0;
        ret_d = '0;
        ch_d  = '0;
        if (t_q == SAW'(N_SAMP - 1)) state_d = DONE;
        else begin
          state_d = ISSUE;
          t_d     = t_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Strobes and addresses are registered from next-state values so they line up with the state they belong to.
    rd_en_d   = state_d == ISSUE;
    rd_addr_d = rd_en_d ? AW'(t_d) + AW'(ch_d) * AW'(N_SAMP) : rd_addr_q;
    wr_en_d   = state_d == WRITE;
    wr_addr_d = wr_en_d ? t_d : wr_addr_q;
    wr_data_d = wr_en_d ? acc_d : wr_data_q;
    busy_d    = state_d != IDLE;
    done_d    = state_d == DONE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q   <= IDLE;
      t_q       <= '0;
      ch_q      <= '0;
      ret_q     <= '0;
      acc_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      ch_q      <= ch_d;
      ret_q     <= ret_d;
      acc_q     <= acc_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_beam_sum_sequencer.sv
// tb_beam_sum_sequencer: scoreboard bench driving three sequencers (RD_LAT 2, 1, 4) against latency-accurate RAM models
module tb_beam_sum_sequencer;
  import beam_sum_sequencer_pkg::*;
  typedef struct packed {logic [9:0] a; logic [39:0] d;} wr_t;
  logic clk = 0, reset = 1, ones = 0;
  logic st [3];
  logic busy_w [3], done_w [3], rden_w [3], wren_w [3];
  logic [12:0] rdaddr_w [3], lasta [3];
  logic [9:0] wraddr_w [3];
  logic [39:0] wrdata_w [3];
  wr_t exp_q [3][$];
  wr_t e;
  bit lastv [3];
  int ncmp = 0, nerr = 0, cyc = 0;
  int dn [3], rc [3], issue0 [3], lastrd [3];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int lat(input int g);
    return g == 0 ? 2 : (g == 1 ? 1 : 4);
  endfunction
  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int L = g == 0 ? 2 : (g == 1 ? 1 : 4);
    beam_sum_sequencer_if bus ();
    logic [3:0] pv = '0;
    logic [12:0] pa [4];
    beam_sum_sequencer #(.RD_LAT(L)) dut (.clk(clk), .reset(reset), .bus(bus.master));
    always @(posedge clk) begin
      for (int i = 3; i > 0; i--) pa[i] <= pa[i-1];
      pa[0] <= bus.rd_addr;
      pv <= {pv[2:0], bus.rd_en};
    end
    assign bus.start   = st[g];
    assign bus.rd_data = pv[L-1] ? (ones ? 32'hFFFF_FFFF : {19'd0, pa[L-1]}) : 32'hA5A5_0F0F;
    assign busy_w[g]   = bus.busy;
    assign done_w[g]   = bus.done;
    assign rden_w[g]   = bus.rd_en;
    assign wren_w[g]   = bus.wr_en;
    assign rdaddr_w[g] = bus.rd_addr;
    assign wraddr_w[g] = bus.wr_addr;
    assign wrdata_w[g] = bus.wr_data;
  end
  task automatic chk(input string nm, input longint got, input longint exp);
    ncmp++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask
  always @(negedge clk)
    for (int g = 0; g < 3; g++)
      if (reset) begin
        rc[g] = 0;
        lastv[g] = 0;
      end else begin
        if (rden_w[g] || wren_w[g]) chk($sformatf("rd_wr_exclusive L%0d", lat(g)), 64'(rden_w[g] & wren_w[g]), 0);
        if (rden_w[g]) begin
          chk($sformatf("rd_addr L%0d r%0d", lat(g), rc[g]), rdaddr_w[g], rc[g] / 8 + 768 * (rc[g] % 8));
          if (rc[g] == 0) issue0[g] = cyc;
          else chk($sformatf("rd_gap L%0d r%0d", lat(g), rc[g]), cyc - lastrd[g], rc[g] % 8 == 0 ? lat(g) + 2 : 1);
          lastrd[g] = cyc;
          rc[g]++;
          lasta[g] = rdaddr_w[g];
          lastv[g] = 1;
        end else if (lastv[g]) chk($sformatf("rd_addr_hold L%0d", lat(g)), rdaddr_w[g], lasta[g]);
        if (wren_w[g]) begin
          ncmp++;
          if (exp_q[g].size() == 0) begin
            nerr++;
            $display("FAIL unexpected_write L%0d: got addr %0d data 0x%0h, required no write (cycle %0d)", lat(g), wraddr_w[g], wrdata_w[g], cyc);
          end else begin
            e = exp_q[g].pop_front();
            if ({wraddr_w[g], wrdata_w[g]} != e) begin
              nerr++;
              $display("FAIL write L%0d: got addr %0d data 0x%0h, required addr %0d data 0x%0h", lat(g), wraddr_w[g], wrdata_w[g], e.a, e.d);
            end
          end
        end
        if (done_w[g]) begin
          dn[g]++;
          chk($sformatf("frame_len L%0d", lat(g)), cyc - issue0[g], 768 * (9 + lat(g)));
          rc[g] = 0;
        end
      end
  task automatic pulse(input logic [2:0] m);
    for (int g = 0; g < 3; g++) st[g] = m[g];
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) st[g] = 0;
  endtask
  task automatic push_frame(input int g, input bit one);
    wr_t w;
    for (int t = 0; t < 768; t++) begin
      w.a = 10'(t);
      w.d = one ? 40'h07_FFFF_FFF8 : 40'(8 * t + 21504);
      exp_q[g].push_back(w);
    end
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy_w[0] || busy_w[1] || busy_w[2]) && n < 12000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_timeout"}, 64'(n >= 12000), 0);
    repeat (20) @(posedge clk);
    #1;
  endtask
  task automatic frame_end(input string nm, input int g, input int ndone);
    chk($sformatf("%s done_count L%0d", nm, lat(g)), dn[g], ndone);
    chk($sformatf("%s pending_writes L%0d", nm, lat(g)), exp_q[g].size(), 0);
    chk($sformatf("%s busy_idle L%0d", nm, lat(g)), busy_w[g], 0);
  endtask
  initial begin
    int n;
    for (int g = 0; g < 3; g++) st[g] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("reset busy", busy_w[g], 0);
      chk("reset done", done_w[g], 0);
      chk("reset rd_en", rden_w[g], 0);
      chk("reset wr_en", wren_w[g], 0);
      chk("reset rd_addr", rdaddr_w[g], 0);
      chk("reset wr_addr", wraddr_w[g], 0);
      chk("reset wr_data", wrdata_w[g], 0);
    end
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) push_frame(g, 0);
    pulse(3'b111);
    for (int g = 0; g < 3; g++) chk("busy_after_start", busy_w[g], 1);
    repeat (4) @(posedge clk);
    #1;
    pulse(3'b111);
    repeat (3994) @(posedge clk);
    #1;
    pulse(3'b111);
    n = 0;
    while (!done_w[0] && n < 10000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen L2", done_w[0], 1);
    pulse(3'b001);
    chk("busy_low_after_done L2", busy_w[0], 0);
    wait_idle("frame_addr");
    for (int g = 0; g < 3; g++) frame_end("frame_addr", g, 1);
    ones = 1;
    for (int g = 0; g < 3; g++) push_frame(g, 1);
    pulse(3'b111);
    wait_idle("frame_ones");
    for (int g = 0; g < 3; g++) frame_end("frame_ones", g, 2);
    ones = 0;
    push_frame(0, 0);
    pulse(3'b001);
    repeat (100) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("midreset busy", busy_w[0], 0);
    chk("midreset rd_en", rden_w[0], 0);
    chk("midreset wr_en", wren_w[0], 0);
    chk("midreset rd_addr", rdaddr_w[0], 0);
    chk("midreset writes_before", 768 - exp_q[0].size(), 9);
    exp_q[0].delete();
    repeat (300) @(posedge clk);
    #1;
    frame_end("after_reset", 0, 2);
    push_frame(0, 0);
    pulse(3'b001);
    wait_idle("frame_rerun");
    frame_end("frame_rerun", 0, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/beam_sum_sequencer.md
BEAM_SUM_SEQUENCER -- requirements
Module: beam_sum_sequencer

Interface
REQ-001 Parameter N_CH, default 8, number of delayed channels summed per output sample.
REQ-002 Parameter N_SAMP, default 768, output samples per channel and per frame.
REQ-003 Parameter RD_LAT, default 2, output-RAM read latency in cycles from rd_en to rd_data valid; legal range 1..4.
REQ-004 Parameter DW, default 32, channel sample width; SW, default 40, sum width; AW, default 13, read address width; SAW, default 10, sum write address width.
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle request to sum one frame; honoured only in IDLE.
REQ-008 busy  out  1  high from the cycle after an accepted start until DONE is left.
REQ-009 done  out  1  one-cycle pulse after the last sum write of a frame.
REQ-010 rd_en  out  1  output-RAM read strobe.
REQ-011 rd_addr  out  AW  output-RAM read address.
REQ-012 rd_data  in  DW  output-RAM read data, valid RD_LAT cycles after rd_en.
REQ-013 wr_en  out  1  sum-RAM write strobe.
REQ-014 wr_addr  out  SAW  sum-RAM write address, equal to sample index t.
REQ-015 wr_data  out  SW  sum-RAM write data.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, WRITE, DONE.
REQ-017 IDLE: outputs inactive; start=1 -> ISSUE with t=0, ch=0, acc=0.
REQ-018 ISSUE: for N_CH consecutive cycles, rd_en=1 and rd_addr=t+N_SAMP*ch, ch = 0..N_CH-1; after ch=N_CH-1 -> WAIT.
REQ-019 A RD_LAT-deep valid shift register tracks issued reads; each valid return adds zero-extended rd_data to acc, also during ISSUE.
REQ-020 WAIT: rd_en=0; leave for WRITE in the cycle after the N_CH-th return has been accumulated.
REQ-021 WRITE: one cycle with wr_en=1, wr_addr=t, wr_data=acc; acc cleared; t=N_SAMP-1 -> DONE, else t+1, ch=0 -> ISSUE.
REQ-022 Per-sample period fixed at N_CH+RD_LAT+1 cycles; default frame = 768*11 = 8448 cycles from the first ISSUE cycle to the last WRITE cycle.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; busy deasserts in the IDLE cycle.
REQ-024 Arithmetic: unsigned; SW >= DW+clog2(N_CH); no overflow or saturation logic.
REQ-025 start while not in IDLE, including in the DONE cycle, is ignored and not queued.
REQ-026 rd_en and wr_en are never high in the same cycle; rd_addr and wr_addr hold their last value when their strobe is low.

Reset
REQ-027 reset=1 forces IDLE, t=0, ch=0, acc=0, valid pipe cleared, busy=0, done=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0 on the next edge; takes priority over start.
REQ-028 Reset mid-frame abandons the frame with no further writes; read data still in flight is discarded.

Structure
REQ-029 N_CH, N_SAMP, DW, SW, AW and SAW defaults plus the FSM state encoding live in the shared filter package used by the delay/sum datapath.
REQ-030 One sub-module, rd_valid_pipe (parameterised RD_LAT shift register of rd_en), is instantiated once; all else is flat.

Verification
REQ-031 RAM model word = address, start pulse -> 768 writes with wr_data[t] = 8t+21504 and wr_addr = t in order; done exactly once, 8448 cycles after the first ISSUE cycle.
REQ-032 All words 0xFFFFFFFF -> every wr_data = 40'h07_FFFF_FFF8, with no truncation.
REQ-033 rd_addr trace -> sample 0 reads 0,768,...,5376; sample 767 reads 767,1535,...,6143; the gap between samples is exactly RD_LAT+1 idle cycles.
REQ-034 start re-pulsed at cycles 5 and 4000 and in the DONE cycle -> no restart or extra writes, and a single done pulse.
REQ-035 reset asserted at cycle 100 of a frame -> next cycle busy=0 and rd_en=wr_en=0 with no later writes; a fresh start reproduces REQ-031 results exactly.
REQ-036 Repeat REQ-031 with RD_LAT=1 and RD_LAT=4 -> identical sums; frame length 768*(N_CH+RD_LAT+1) cycles.
